// File: rtl/pio_key_debounce_if.sv
// Register-bus port bundle for the debounced key PIO: one address/strobe bus,
// registered read data and a level interrupt.
interface pio_key_debounce_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, chipselect, write_n, writedata,
                    input  readdata, irq);
    modport slave  (input  address, chipselect, write_n, writedata,
                    output readdata, irq);
endinterface

// File: rtl/pio_key_debounce.sv
// Debounced key PIO: per-bit synchroniser and stability counter, edge capture
// with write-1-to-clear, level irq, and a small register map with registered reads.
module pio_key_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key,
    input  logic db_en,
    input  logic cnt_clr,
    output logic raw,
    output logic data,
    output logic data_d
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;

    assign raw = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= '0;
            cnt    <= '0;
            data   <= 1'b0;
            data_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], key};
            data_d <= data;
            if (!db_en) begin
                data <= raw;
                cnt  <= '0;
            end else if (raw == data) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // counter stops here, so it can never wrap
                data <= raw;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (cnt_clr) cnt <= '0;
        end
    end
endmodule

module pio_key_debounce #(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pio_key_debounce_if.slave     bus,
    input  logic [WIDTH-1:0]      in_port
);
    logic [WIDTH-1:0] raw, data, data_d;
    logic [WIDTH-1:0] irq_mask, edge_capture, rise_en, fall_en, db_en;
    logic [WIDTH-1:0] wr_data, cnt_clr, ec_set, ec_clr;
    logic [31:0]      rd_next;
    logic             wr;

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wr_data = bus.writedata[WIDTH-1:0];
    // only bits whose enable actually flips restart their count
    assign cnt_clr = (wr && bus.address == 3'd6) ? (wr_data ^ db_en) : '0;
    assign ec_clr  = (wr && bus.address == 3'd3) ? wr_data : '0;
    assign ec_set  = (data & ~data_d & rise_en) | (~data & data_d & fall_en);
    assign bus.irq = |(edge_capture & irq_mask);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            pio_key_lane #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .key     (in_port[i]),
                .db_en   (db_en[i]),
                .cnt_clr (cnt_clr[i]),
                .raw     (raw[i]),
                .data    (data[i]),
                .data_d  (data_d[i])
            );
        end
        if (WIDTH < 32) begin : g_unused
            logic unused_wd;
            assign unused_wd = ^bus.writedata[31:WIDTH];
        end
    endgenerate

    always_comb begin
        rd_next = '0;
        case (bus.address)
            3'd0:    rd_next[WIDTH-1:0] = data;
            3'd1:    rd_next[WIDTH-1:0] = raw;
            3'd2:    rd_next[WIDTH-1:0] = irq_mask;
            3'd3:    rd_next[WIDTH-1:0] = edge_capture;
            3'd4:    rd_next[WIDTH-1:0] = rise_en;
            3'd5:    rd_next[WIDTH-1:0] = fall_en;
            3'd6:    rd_next[WIDTH-1:0] = db_en;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            rise_en      <= '0;
            fall_en      <= '1;
            db_en        <= '1;
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_next;
            // a fresh edge beats a simultaneous clear
            edge_capture <= (edge_capture & ~ec_clr) | ec_set;
            if (wr) begin
                case (bus.address)
                    3'd2:    irq_mask <= wr_data;
                    3'd4:    rise_en  <= wr_data;
                    3'd5:    fall_en  <= wr_data;
                    3'd6:    db_en    <= wr_data;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pio_key_debounce.sv
// Directed bench for pio_key_debounce at WIDTH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_pio_key_debounce;
    logic       clk;
    logic       reset_n;
    logic [2:0] in_port;
    int         total;
    int         bad;
    logic [31:0] v;

    pio_key_debounce_if bus();

    pio_key_debounce #(
        .WIDTH           (3),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick(1);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        tick(1);
        d = bus.readdata;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n        = 1'b0;
        in_port        = 3'b000;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        tick(2);
        chk("rst_data",     32'(dut.data), 32'h0);
        chk("rst_ec",       32'(dut.edge_capture), 32'h0);
        chk("rst_irq",      32'(bus.irq), 32'h0);
        chk("rst_readdata", bus.readdata, 32'h0);
        chk("rst_fall_en",  32'(dut.fall_en), 32'h7);
        chk("rst_db_en",    32'(dut.db_en), 32'h7);
        chk("rst_rise_en",  32'(dut.rise_en), 32'h0);
        reset_n = 1'b1;
        tick(1);

        // debounced rise on bit 0
        wr(3'd4, 32'h1);
        wr(3'd2, 32'h1);
        in_port = 3'b001;
        tick(2);
        chk("r31_raw",      32'(dut.raw), 32'h1);
        chk("r31_data_pre", 32'(dut.data), 32'h0);
        tick(3);
        chk("r31_data_3",   32'(dut.data), 32'h0);
        tick(1);
        chk("r31_data_4",   32'(dut.data), 32'h1);
        chk("r31_irq_pre",  32'(bus.irq), 32'h0);
        tick(1);
        chk("r31_ec",       32'(dut.edge_capture), 32'h1);
        chk("r31_irq",      32'(bus.irq), 32'h1);
        wr(3'd3, 32'h1);
        chk("r31_ec_clr",   32'(dut.edge_capture), 32'h0);
        chk("r31_irq_clr",  32'(bus.irq), 32'h0);

        // 3-cycle glitch on bit 1 is rejected
        in_port = 3'b011;
        tick(3);
        in_port = 3'b001;
        tick(10);
        chk("r32_data", 32'(dut.data), 32'h1);
        chk("r32_ec",   32'(dut.edge_capture), 32'h0);
        chk("r32_irq",  32'(bus.irq), 32'h0);

        // bit1 rise + bit0 fall, then partial W1C
        wr(3'd4, 32'h7);
        in_port = 3'b010;
        tick(6);
        chk("r33_data", 32'(dut.data), 32'h2);
        tick(1);
        chk("r33_ec",   32'(dut.edge_capture), 32'h3);
        chk("r33_irq",  32'(bus.irq), 32'h1);
        wr(3'd3, 32'h2);
        chk("r33_ec_w1c", 32'(dut.edge_capture), 32'h1);
        chk("r33_irq_m1", 32'(bus.irq), 32'h1);
        wr(3'd2, 32'h2);
        chk("r33_irq_m2", 32'(bus.irq), 32'h0);
        wr(3'd3, 32'h1);
        chk("r33_ec_clr", 32'(dut.edge_capture), 32'h0);

        // set wins over a coincident clear on bit 2
        wr(3'd6, 32'h0);
        in_port = 3'b110;
        tick(4);
        chk("r34_ec_rise", 32'(dut.edge_capture), 32'h4);
        wr(3'd3, 32'h4);
        chk("r34_ec_clr",  32'(dut.edge_capture), 32'h0);
        in_port = 3'b010;
        tick(3);
        wr(3'd3, 32'h4);
        chk("r34_set_wins", 32'(dut.edge_capture), 32'h4);
        wr(3'd3, 32'h7);

        // bypass latency, 111 -> 000
        in_port = 3'b111;
        tick(4);
        wr(3'd3, 32'h7);
        chk("r35_ec0",   32'(dut.edge_capture), 32'h0);
        chk("r35_data1", 32'(dut.data), 32'h7);
        in_port = 3'b000;
        tick(2);
        chk("r35_raw",      32'(dut.raw), 32'h0);
        chk("r35_data_hold", 32'(dut.data), 32'h7);
        tick(1);
        chk("r35_data",  32'(dut.data), 32'h0);
        tick(1);
        chk("r35_ec",    32'(dut.edge_capture), 32'h7);
        chk("r35_irq",   32'(bus.irq), 32'h1);
        rd(3'd0, v);
        chk("r35_rd_data", v, 32'h0);
        rd(3'd3, v);
        chk("r35_rd_ec",   v, 32'h7);
        rd(3'd7, v);
        chk("r35_rd_rsvd", v, 32'h0);
        rd(3'd6, v);
        chk("r35_rd_dben", v, 32'h0);
        rd(3'd5, v);
        chk("r35_rd_fall", v, 32'h7);

        // reset mid-debounce
        wr(3'd6, 32'h7);
        wr(3'd3, 32'h7);
        in_port = 3'b001;
        tick(4);
        chk("r36_cnt", 32'(dut.g_lane[0].u_lane.cnt), 32'h2);
        reset_n = 1'b0;
        in_port = 3'b000;
        tick(1);
        chk("r36_rst_data", 32'(dut.data), 32'h0);
        chk("r36_rst_cnt",  32'(dut.g_lane[0].u_lane.cnt), 32'h0);
        chk("r36_rst_mask", 32'(dut.irq_mask), 32'h0);
        chk("r36_rst_dben", 32'(dut.db_en), 32'h7);
        chk("r36_rst_rd",   bus.readdata, 32'h0);
        reset_n = 1'b1;
        tick(8);
        chk("r36_ec",   32'(dut.edge_capture), 32'h0);
        chk("r36_irq",  32'(bus.irq), 32'h0);
        chk("r36_data", 32'(dut.data), 32'h0);

        // key held after reset rises through the debounce path
        wr(3'd4, 32'h1);
        in_port = 3'b001;
        tick(5);
        chk("r30_data_pre", 32'(dut.data), 32'h0);
        tick(1);
        chk("r30_data", 32'(dut.data), 32'h1);
        tick(1);
        chk("r30_ec",   32'(dut.edge_capture), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pio_key_debounce.md
PIO_KEY_DEBOUNCE -- requirements
Module: pio_key_debounce

Interface
REQ-001 Parameter WIDTH, default 3, number of input bits (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flops per bit (2..4).
REQ-003 Parameter DEBOUNCE_CYCLES, default 50000, stable cycles required before the debounced value changes (>=1).
REQ-004 Port clk  input  1  sole clock, all state on rising edge.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port address  input  3  register select.
REQ-007 Port chipselect  input  1  slave select.
REQ-008 Port write_n  input  1  active-low write strobe, valid with chipselect.
REQ-009 Port writedata  input  32  write data, bits [WIDTH-1:0] used.
REQ-010 Port in_port  input  WIDTH  asynchronous key inputs.
REQ-011 Port readdata  output  32  registered read data, bits above WIDTH read 0.
REQ-012 Port irq  output  1  level interrupt, OR of (edge_capture AND irq_mask).

Function
REQ-013 Register map SHALL be: 0 data (debounced, RO); 1 raw (synchronised, RO); 2 irq_mask (RW); 3 edge_capture (write-1-to-clear); 4 rise_en (RW); 5 fall_en (RW); 6 db_en (RW); 7 reserved, reads 0.
REQ-014 Write SHALL occur when chipselect=1 and write_n=0; writes to addresses 0, 1, 7 are ignored.
REQ-015 readdata SHALL be registered every clock from the current address regardless of chipselect; read latency one cycle.
REQ-016 Each in_port bit SHALL pass through SYNC_STAGES flops; the last stage is "raw".
REQ-017 Per bit with db_en=1: counter clears when raw equals data; increments each cycle raw differs; when counter = DEBOUNCE_CYCLES-1 and raw still differs, data takes raw and counter clears.
REQ-018 Per bit with db_en=0: data SHALL take raw on the next clock (equivalent to DEBOUNCE_CYCLES=1).
REQ-019 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter SHALL NOT wrap.
REQ-020 Writing db_en SHALL clear the counters of all bits whose db_en value changes.
REQ-021 A registered copy data_d SHALL hold the previous data; rise = data AND NOT data_d; fall = NOT data AND data_d.
REQ-022 edge_capture[i] SHALL set on the clock after (rise[i] AND rise_en[i]) OR (fall[i] AND fall_en[i]).
REQ-023 A write of 1 to edge_capture[i] SHALL clear it; a write of 0 SHALL leave it unchanged.
REQ-024 If a clear and a new edge on the same bit occur in the same cycle, the set SHALL win.
REQ-025 irq SHALL be combinational from edge_capture and irq_mask, with no added latency.
REQ-026 Latency with db_en=0: an in_port transition SHALL appear in raw after SYNC_STAGES clocks, in data 1 clock later, and in edge_capture 2 clocks after raw.

Reset
REQ-027 While reset_n=0: synchronisers, data, data_d, counters, edge_capture, irq_mask, rise_en and readdata SHALL be 0, and irq SHALL be 0.
REQ-028 While reset_n=0: fall_en SHALL be all ones and db_en SHALL be all ones.
REQ-029 Reset asserted mid-debounce SHALL discard the count; no edge SHALL be captured from the reset itself.
REQ-030 After reset release, data SHALL take any in_port value of 1 via the normal debounce path and SHALL generate a rise event.

Verification (WIDTH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-031 in_port[0] 0->1 held -> data[0]=1 exactly 4 clocks after raw[0]=1; with rise_en=001 and irq_mask=001, irq=1 on the following clock.
REQ-032 in_port[1] glitch to 1 for 3 cycles, then back to 0 -> data[1] stays 0, edge_capture stays 000, irq=0.
REQ-033 edge_capture=011, write 0x2 to address 3 -> edge_capture=001; irq follows the mask.
REQ-034 W1C of bit 2 coincident with a new fall on bit 2 -> edge_capture[2]=1 after that clock.
REQ-035 db_en=000, in_port 111->000 -> raw=000 after 2 clocks, data=000 after 1 more, edge_capture=111 after 1 more; reading address 0 returns 0x0 one cycle after address is presented.
REQ-036 reset_n pulsed low at counter=2 -> all registers return to reset values; on release with in_port=000 there is no capture and irq=0.
